vga_glyph_scan_ctrl: RTL

- Upstream scan and timing controller for the 16-bit glyph text-mode renderer.
- Generates 640x480@60 Hz VGA timing from the system clock using a divide-by-CLK_DIV pixel slot.
- Issues one-cycle `req` pulses with the coordinates of the next visible pixel to the glyph renderer, then samples the renderer's `color` result.
- Drives registered hsync, vsync and 8-bit RRRGGGBB pixel data to the DAC pins.

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_slot_counter.sv | 58 +++++
 rtl/vga_glyph_scan_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions for the glyph text-mode scan path:
// default 640x480@60 geometry, derived totals and sync window helpers,
// and the RRRGGGBB pixel type.
package vga_timing_pkg;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;

   // Total slots in one line or lines in one frame.
   function automatic int span_total(input int visible, input int fp,
                                     input int sync, input int bp);
      return visible + fp + sync + bp;
   endfunction

   // First slot or line in which the sync pulse is asserted.
   function automatic int sync_first(input int visible, input int fp);
      return visible + fp;
   endfunction

   // Last slot or line in which the sync pulse is asserted.
   function automatic int sync_last(input int visible, input int fp, input int sync);
      return visible + fp + sync - 1;
   endfunction

   localparam int H_TOTAL = span_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int V_TOTAL = span_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

endpackage

// File: rtl/vga_slot_counter.sv
// Pixel-slot timebase: a phase counter dividing the system clock into
// pixel slots, plus the horizontal and vertical position counters. Also
// reports the coordinates of the slot that follows the current one.
module vga_slot_counter
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int H_TOT   = H_TOTAL,
   parameter int V_TOT   = V_TOTAL
) (
   input  logic       clk,
   input  logic       rst,
   output logic       phase0,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic [9:0] next_h,
   output logic [9:0] next_v
);

   localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]  PHASE_LAST = PW'(CLK_DIV - 1);
   localparam logic [9:0]     H_LAST     = 10'(H_TOT - 1);
   localparam logic [9:0]     V_LAST     = 10'(V_TOT - 1);

   logic [PW-1:0] phase;

   // Advance the phase every clock; on phase wrap step across the line, then down the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase  <= '0;
         hcount <= '0;
         vcount <= '0;
      end else if (phase == PHASE_LAST) begin
         phase <= '0;
         if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
         end else begin
            hcount <= hcount + 10'd1;
         end
      end else begin
         phase <= phase + PW'(1);
      end
   end

   assign phase0 = (phase == '0);

   // Coordinates of the slot after the current one, wrapping at line and frame ends.
   always_comb begin
      next_h = hcount + 10'd1;
      next_v = vcount;
      if (hcount == H_LAST) begin
         next_h = '0;
         next_v = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end
   end

endmodule

// File: rtl/vga_glyph_scan_ctrl.sv
// Scan and timing controller for the glyph text-mode renderer. Requests the
// next visible pixel one slot ahead, captures the renderer's colour at the
// end of phase 0, and drives registered sync and pixel outputs to the DAC.
module vga_glyph_scan_ctrl
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] color,
   output logic       req,
   output logic [9:0] req_col,
   output logic [8:0] req_row,
   output logic       hsync,
   output logic       vsync,
   output logic [7:0] rgb,
   output logic       frame_start
);

   localparam int         H_TOT    = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
   localparam int         V_TOT    = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(sync_first(H_VISIBLE, H_FP));
   localparam logic [9:0] HS_LAST  = 10'(sync_last(H_VISIBLE, H_FP, H_SYNC));
   localparam logic [9:0] VS_FIRST = 10'(sync_first(V_VISIBLE, V_FP));
   localparam logic [9:0] VS_LAST  = 10'(sync_last(V_VISIBLE, V_FP, V_SYNC));

   logic       phase0;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic [9:0] next_h;
   logic [9:0] next_v;
   logic       primed;
   logic       cur_visible;
   logic       hsync_next;
   logic       vsync_next;
   rgb332_t    pixel_next;

   vga_slot_counter #(
      .CLK_DIV (CLK_DIV),
      .H_TOT   (H_TOT),
      .V_TOT   (V_TOT)
   ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .phase0 (phase0),
      .hcount (hcount),
      .vcount (vcount),
      .next_h (next_h),
      .next_v (next_v)
   );

   // Request the following slot's pixel during phase 0, only when it is visible and never under reset.
   always_comb begin
      req     = 1'b0;
      req_col = '0;
      req_row = '0;
      if (!rst && phase0 && (next_h < H_VIS) && (next_v < V_VIS)) begin
         req     = 1'b1;
         req_col = next_h;
         req_row = next_v[8:0];
      end
   end

   assign cur_visible = (hcount < H_VIS) && (vcount < V_VIS);
   assign hsync_next  = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
   assign vsync_next  = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));

   // Pass the renderer colour only for visible slots that had a request issued one slot earlier.
   always_comb begin
      pixel_next = '0;
      if (cur_visible && primed) begin
         pixel_next = rgb332_t'(color);
      end
   end

   // Capture sync, pixel and frame marker at the end of phase 0 so all DAC outputs share one lag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb         <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
         primed      <= 1'b0;
      end else begin
         frame_start <= phase0 && (hcount == 10'd0) && (vcount == 10'd0);
         if (phase0) begin
            rgb   <= pixel_next;
            hsync <= hsync_next;
            vsync <= vsync_next;
            if (req) begin
               primed <= 1'b1;
            end
         end
      end
   end

endmodule
